// File: rtl/de10_disp_pkg.sv
// Shared display definitions for the DE10-Lite debug path.
// Active-low 7-segment glyphs, bit order {dp,g,f,e,d,c,b,a}.
package de10_disp_pkg;

   typedef logic [7:0] seg_t;

   localparam seg_t SEG_L     = 8'hC7;
   localparam seg_t SEG_H     = 8'h89;
   localparam seg_t SEG_E     = 8'h86;
   localparam seg_t SEG_DASH  = 8'hBF;
   localparam seg_t SEG_BLANK = 8'hFF;

   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t seg;
      seg = SEG_BLANK;
      unique case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         4'hF: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/vdata_hex_display_if.sv
// Signal bundle between the selector/board and the hex display block.
// master drives Vdata/SEL_LED/KEY_PAGE; slave drives the displays.
interface vdata_hex_display_if;
   import de10_disp_pkg::*;

   logic [31:0] Vdata;
   logic [4:0]  SEL_LED;
   logic        KEY_PAGE;
   seg_t        HEX0;
   seg_t        HEX1;
   seg_t        HEX2;
   seg_t        HEX3;
   seg_t        HEX4;
   seg_t        HEX5;
   logic        PAGE_LED;

   modport master (
      output Vdata, SEL_LED, KEY_PAGE,
      input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, PAGE_LED
   );

   modport slave (
      input  Vdata, SEL_LED, KEY_PAGE,
      output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, PAGE_LED
   );

endinterface

// File: rtl/vdata_hex_display_key_debounce.sv
// Page button path: 2-flop synchronizer and level debouncer.
// press pulses for the single cycle in which the stable level falls.
module key_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_stable,
   output logic press
);

   localparam int DW = $clog2(DB_CYCLES);
   localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic          stable_q, stable_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 2'b11;
         stable_q <= 1'b1;
         db_cnt_q <= '0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   always_comb begin
      sync_d   = {sync_q[0], key_n};
      stable_d = stable_q;
      db_cnt_d = '0;
      press    = 1'b0;
      if (sync_q[1] != stable_q) begin
         if (db_cnt_q == DB_MAX) begin
            stable_d = sync_q[1];
            press    = ~sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end
   end

   assign key_stable = stable_q;

endmodule

// File: rtl/vdata_hex_display.sv
// Snapshots Vdata/SEL_LED periodically and renders one 16-bit page
// on HEX3..HEX0, source on HEX4 and page letter on HEX5.
module vdata_hex_display
   import de10_disp_pkg::*;
#(
   parameter int DB_CYCLES    = 500000,
   parameter int SNAP_CYCLES  = 5000000,
   parameter int FLASH_CYCLES = 25000000
) (
   input logic                CLK,
   input logic                RST,
   vdata_hex_display_if.slave io
);

   localparam int SW = $clog2(SNAP_CYCLES);
   localparam int FW = $clog2(FLASH_CYCLES + 1);
   localparam logic [SW-1:0] SNAP_MAX   = SW'(SNAP_CYCLES - 1);
   localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

   logic [SW-1:0]   snap_cnt_q, snap_cnt_d;
   logic [31:0]     snap_q, snap_d;
   logic [4:0]      src_q, src_d;
   logic [FW-1:0]   flash_q, flash_d;
   logic            page_q, page_d;
   logic [5:0][7:0] hex_q, hex_d;

   logic        key_stable;
   logic        press;
   logic        wrap;
   logic [15:0] half;

   key_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_key (
      .clk       (CLK),
      .rst       (RST),
      .key_n     (io.KEY_PAGE),
      .key_stable(key_stable),
      .press     (press)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         snap_cnt_q <= '0;
         snap_q     <= '0;
         src_q      <= '0;
         flash_q    <= '0;
         page_q     <= 1'b0;
         hex_q      <= {6{SEG_BLANK}};
      end else begin
         snap_cnt_q <= snap_cnt_d;
         snap_q     <= snap_d;
         src_q      <= src_d;
         flash_q    <= flash_d;
         page_q     <= page_d;
         hex_q      <= hex_d;
      end
   end

   always_comb begin
      wrap       = (snap_cnt_q == SNAP_MAX);
      snap_cnt_d = wrap ? '0 : snap_cnt_q + SW'(1);
      snap_d     = wrap ? io.Vdata : snap_q;
      src_d      = wrap ? io.SEL_LED : src_q;
      flash_d    = flash_q;
      if (wrap && (io.Vdata != snap_q)) begin
         flash_d = FLASH_LOAD;
      end else if (flash_q != '0) begin
         flash_d = flash_q - FW'(1);
      end
      // press is only raised while the stable level is still high
      page_d = page_q ^ (press & key_stable);
   end

   always_comb begin
      half     = page_q ? snap_q[31:16] : snap_q[15:0];
      hex_d[0] = hex_to_seg(half[3:0]) & {(flash_q == '0), 7'h7F};
      hex_d[1] = hex_to_seg(half[7:4]);
      hex_d[2] = hex_to_seg(half[11:8]);
      hex_d[3] = hex_to_seg(half[15:12]);
      hex_d[4] = SEG_DASH;
      unique case (src_q)
         5'b00001: hex_d[4] = hex_to_seg(4'd0);
         5'b00010: hex_d[4] = hex_to_seg(4'd1);
         5'b00100: hex_d[4] = hex_to_seg(4'd2);
         5'b01000: hex_d[4] = hex_to_seg(4'd3);
         5'b10000: hex_d[4] = hex_to_seg(4'd4);
         5'b11111: hex_d[4] = SEG_E;
         default:  hex_d[4] = SEG_DASH;
      endcase
      hex_d[5] = page_q ? SEG_H : SEG_L;
   end

   assign io.HEX0     = hex_q[0];
   assign io.HEX1     = hex_q[1];
   assign io.HEX2     = hex_q[2];
   assign io.HEX3     = hex_q[3];
   assign io.HEX4     = hex_q[4];
   assign io.HEX5     = hex_q[5];
   assign io.PAGE_LED = page_q;

endmodule
